// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX_VAL+1) counter with load, clear, wrap/saturate, tc pulse and sticky overflow.
// Define COUNTER_PRESCALE_EN to step only once every PRESC enabled cycles.
module updown_mod_counter #(
    parameter int WIDTH   = 7,
    parameter int MAX_VAL = 99,
    parameter int PRESC   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             step_s;
    logic             at_bound_s;

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;

    assign step_s = cnt_en && (presc_r == PRESC_LAST);

    // Prescaler next state: zeroed by clr/load, advances on enabled cycles, wraps at PRESC-1.
    always_comb begin
        presc_nxt_s = presc_r;
        if (clr || load) begin
            presc_nxt_s = {PW{1'b0}};
        end else if (step_s) begin
            presc_nxt_s = {PW{1'b0}};
        end else if (cnt_en) begin
            presc_nxt_s = presc_r + 1'b1;
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_nxt_s;
        end
    end
`else
    assign step_s = cnt_en;
`endif

    assign at_bound_s = dir ? (count_r == MAX_C) : (count_r == ZERO_C);

    // Next-state logic in priority order clr > load > step > hold; a bound event beats ovf_clr.
    always_comb begin
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        ovf_nxt_s   = ovf_r;
        if (clr) begin
            count_nxt_s = ZERO_C;
            ovf_nxt_s   = 1'b0;
        end else if (load) begin
            count_nxt_s = (load_val > MAX_C) ? MAX_C : load_val;
            ovf_nxt_s   = ovf_clr ? 1'b0 : ovf_r;
        end else if (step_s) begin
            if (at_bound_s) begin
                tc_nxt_s    = 1'b1;
                ovf_nxt_s   = 1'b1;
                if (sat_mode) begin
                    count_nxt_s = count_r;
                end else begin
                    count_nxt_s = dir ? ZERO_C : MAX_C;
                end
            end else begin
                count_nxt_s = dir ? (count_r + 1'b1) : (count_r - 1'b1);
                ovf_nxt_s   = ovf_clr ? 1'b0 : ovf_r;
            end
        end else begin
            ovf_nxt_s = ovf_clr ? 1'b0 : ovf_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= ZERO_C;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign out = count_r;
    assign tc  = tc_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter (WIDTH=7, MAX_VAL=99).
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n, cnt_en, dir, sat_mode, clr, load, ovf_clr;
    logic [6:0] load_val;
    logic [6:0] out;
    logic       tc, ovf;
    int         n_cmp = 0;
    int         n_err = 0;

    updown_mod_counter #(.WIDTH(7), .MAX_VAL(99), .PRESC(4)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .dir(dir), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .out(out), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; cnt_en = 1'b0; dir = 1'b1; sat_mode = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = 7'd0; ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (out !== 7'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL reset: out=%0d tc=%b ovf=%b, want 0 0 0", out, tc, ovf);
        end
    endtask

`ifndef COUNTER_PRESCALE_EN
    task automatic test_count_hold();
        rst_n = 1'b1; cnt_en = 1'b1; dir = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (out !== 7'(i) || tc !== 1'b0) begin
                n_err++; $display("FAIL count_up: out=%0d tc=%b, want %0d 0", out, tc, i);
            end
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++; $display("FAIL count_ovf: ovf=%b, want 0", ovf);
        end
        cnt_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (out !== 7'd5 || tc !== 1'b0) begin
            n_err++; $display("FAIL hold: out=%0d tc=%b, want 5 0", out, tc);
        end
    endtask

    task automatic test_wrap_up();
        logic [6:0] exp_out [3] = '{7'd98, 7'd99, 7'd0};
        logic       exp_tc  [3] = '{1'b0, 1'b0, 1'b1};
        load = 1'b1; load_val = 7'd97;
        tick();
        load = 1'b0;
        n_cmp++;
        if (out !== 7'd97 || tc !== 1'b0) begin
            n_err++; $display("FAIL load97: out=%0d tc=%b, want 97 0", out, tc);
        end
        cnt_en = 1'b1; dir = 1'b1; sat_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out !== exp_out[i] || tc !== exp_tc[i]) begin
                n_err++; $display("FAIL wrap_up[%0d]: out=%0d tc=%b, want %0d %b", i, out, tc, exp_out[i], exp_tc[i]);
            end
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++; $display("FAIL wrap_ovf: ovf=%b, want 1", ovf);
        end
        cnt_en = 1'b0;
        tick();
        n_cmp++;
        if (out !== 7'd0 || tc !== 1'b0 || ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_sticky: out=%0d tc=%b ovf=%b, want 0 0 1", out, tc, ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++; $display("FAIL ovf_clr: ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_sat_up();
        load = 1'b1; load_val = 7'd120;
        tick();
        load = 1'b0;
        n_cmp++;
        if (out !== 7'd99 || tc !== 1'b0) begin
            n_err++; $display("FAIL load_clamp: out=%0d tc=%b, want 99 0", out, tc);
        end
        cnt_en = 1'b1; dir = 1'b1; sat_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (out !== 7'd99 || tc !== 1'b1 || ovf !== 1'b1) begin
                n_err++; $display("FAIL sat_up[%0d]: out=%0d tc=%b ovf=%b, want 99 1 1", i, out, tc, ovf);
            end
        end
        cnt_en = 1'b0;
        tick();
        n_cmp++;
        if (out !== 7'd99 || tc !== 1'b0) begin
            n_err++; $display("FAIL sat_idle: out=%0d tc=%b, want 99 0", out, tc);
        end
    endtask

    task automatic test_down();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (out !== 7'd0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL clr: out=%0d ovf=%b, want 0 0", out, ovf);
        end
        cnt_en = 1'b1; dir = 1'b0; sat_mode = 1'b0;
        tick();
        n_cmp++;
        if (out !== 7'd99 || tc !== 1'b1 || ovf !== 1'b1) begin
            n_err++; $display("FAIL wrap_down: out=%0d tc=%b ovf=%b, want 99 1 1", out, tc, ovf);
        end
        tick();
        n_cmp++;
        if (out !== 7'd98 || tc !== 1'b0) begin
            n_err++; $display("FAIL step_down: out=%0d tc=%b, want 98 0", out, tc);
        end
        cnt_en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; cnt_en = 1'b1; sat_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (out !== 7'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
                n_err++; $display("FAIL sat_down[%0d]: out=%0d tc=%b ovf=%b, want 0 1 1", i, out, tc, ovf);
            end
        end
        cnt_en = 1'b0; sat_mode = 1'b0;
    endtask

    task automatic test_priority();
        load = 1'b1; load_val = 7'd99;
        tick();
        load = 1'b0; cnt_en = 1'b1; dir = 1'b1; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (out !== 7'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            n_err++; $display("FAIL bound_beats_ovf_clr: out=%0d tc=%b ovf=%b, want 0 1 1", out, tc, ovf);
        end
        clr = 1'b1; load = 1'b1; load_val = 7'd10;
        tick();
        clr = 1'b0; load = 1'b0;
        n_cmp++;
        if (out !== 7'd0 || ovf !== 1'b0 || tc !== 1'b0) begin
            n_err++; $display("FAIL clr_over_load: out=%0d ovf=%b tc=%b, want 0 0 0", out, ovf, tc);
        end
        load = 1'b1; load_val = 7'd40; cnt_en = 1'b1;
        tick();
        n_cmp++;
        if (out !== 7'd40) begin
            n_err++; $display("FAIL load_over_step: out=%0d, want 40", out);
        end
        load = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out !== 7'd42) begin
            n_err++; $display("FAIL reach42: out=%0d, want 42", out);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (out !== 7'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL reset_mid: out=%0d tc=%b ovf=%b, want 0 0 0", out, tc, ovf);
        end
        cnt_en = 1'b0;
    endtask
`else
    task automatic test_prescale();
        rst_n = 1'b1; cnt_en = 1'b1; dir = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_cmp++;
            if (out !== 7'(i / 4)) begin
                n_err++; $display("FAIL prescale[%0d]: out=%0d, want %0d", i, out, i / 4);
            end
        end
        cnt_en = 1'b0;
        tick();
        tick();
        cnt_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (out !== ((i == 4) ? 7'd4 : 7'd3)) begin
                n_err++; $display("FAIL prescale_hold[%0d]: out=%0d, want %0d", i, out, (i == 4) ? 4 : 3);
            end
        end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
`ifndef COUNTER_PRESCALE_EN
        test_count_hold();
        test_wrap_up();
        test_sat_up();
        test_down();
        test_priority();
`else
        test_prescale();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
